serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal values are 2 to 32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin an addition; sampled on the rising edge of clk.
REQ-005 SHALL have port a, input, WIDTH bits: operand A, unsigned.
REQ-006 SHALL have port b, input, WIDTH bits: operand B, unsigned.
REQ-007 SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when sum holds a new result.
REQ-009 SHALL have port sum, output, WIDTH+1 bits: registered result, {carry_out, sum[WIDTH-1:0]}.

Function
REQ-010 SHALL implement an FSM with states IDLE, RUN and DONE; the state encoding is free.
REQ-011 SHALL, in IDLE with start=1 at an edge, capture a and b into internal shift registers, clear the carry register and the bit counter, and enter RUN.
REQ-012 SHALL, in IDLE with start=0, remain in IDLE and leave all outputs unchanged.
REQ-013 SHALL perform one bit position per RUN cycle, LSB first, using a full-adder cell: s = a0^b0^c, c_next = (a0&b0) | (c&(a0^b0)).
REQ-014 SHALL build the full-adder cell from two cascaded half-adder stages (XOR/AND) plus an OR on the two carries.
REQ-015 SHALL, on each RUN edge, shift both operand registers right by one, shift s into the MSB of the result shift register, update the carry register, and increment the counter.
REQ-016 SHALL leave RUN for DONE on the edge that processes bit WIDTH-1, i.e. after exactly WIDTH RUN edges.
REQ-017 SHALL, on that edge, load sum with {c_next, result bits}, deassert busy and assert done.
REQ-018 SHALL return from DONE to IDLE unconditionally after one cycle; done SHALL be high for exactly that one cycle.
REQ-019 SHALL drive busy high exactly while in RUN and low in IDLE and DONE.
REQ-020 SHALL hold sum at the previous result throughout RUN and change it only on entry to DONE or on reset.
REQ-021 SHALL set timing so that, with start accepted at edge T, done is high between edges T+WIDTH and T+WIDTH+1.
REQ-022 SHALL ignore start while in RUN or DONE; no queuing occurs.
REQ-023 SHALL ignore changes on a and b after capture; the result uses the captured values only.
REQ-024 SHALL, with start held continuously high, accept a new operation every WIDTH+2 edges.
REQ-025 SHALL produce an unsigned result with no overflow loss: sum = a + b, where sum[WIDTH] is the final carry.

Reset
REQ-026 SHALL, on an rst=1 edge, set state to IDLE, busy=0, done=0, sum=0, and clear the carry register, counter and shift registers.
REQ-027 SHALL give rst priority over start on the same edge.
REQ-028 SHALL make rst during RUN abort the operation with no done pulse, leaving sum=0.
REQ-029 SHALL make rst during DONE force done=0 on the following cycle.

Verification
REQ-030 SHALL cover reset with start=0 held for 5 cycles -> busy=0, done=0, sum=9'h000 throughout.
REQ-031 SHALL cover WIDTH=8, a=8'h03, b=8'h05, start pulsed one cycle -> busy high for 8 cycles, then done pulses once with sum=9'h008.
REQ-032 SHALL cover a=8'hFF, b=8'h01 -> sum=9'h100; and a=8'hFF, b=8'hFF -> sum=9'h1FE (carry propagates through all bits).
REQ-033 SHALL cover start held high with a=8'h10, b=8'h20 -> done pulses every 10 cycles, each time with sum=9'h030.
REQ-034 SHALL cover a changed from 8'h01 to 8'hAA and start pulsed, both during RUN of 8'h01+8'h01 -> sum=9'h002 and only one done pulse.
REQ-035 SHALL cover rst asserted on the 4th RUN cycle of 8'h7F+8'h01 -> busy=0 next cycle, no done pulse, sum=9'h000.

Source files
------------

// File: rtl/serial_adder.sv
`default_nettype none
//==============================================================================
// Module      : serial_adder
// Description : Bit-serial unsigned adder, one bit per clock, LSB first,
//               producing a WIDTH+1 bit result with a one-cycle done pulse.
// Revision    : 1.0 - initial release
//==============================================================================
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   sum
);

   localparam int                 c_cnt_w = $clog2(WIDTH);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_res;
   logic               r_carry;
   logic [c_cnt_w-1:0] r_cnt;
   logic [WIDTH:0]     r_sum;

   logic               w_ha1_s;
   logic               w_ha1_c;
   logic               w_ha2_c;
   logic               w_s;
   logic               w_c_next;
   logic               w_last;

   // Full adder as two cascaded half adders plus an OR of their carries
   assign w_ha1_s  = r_a[0] ^ r_b[0];
   assign w_ha1_c  = r_a[0] & r_b[0];
   assign w_s      = w_ha1_s ^ r_carry;
   assign w_ha2_c  = w_ha1_s & r_carry;
   assign w_c_next = w_ha1_c | w_ha2_c;

   assign w_last   = (r_cnt == c_last);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start)  w_state_nxt = RUN;
         RUN:     if (w_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_res   <= '0;
                  r_carry <= 1'b0;
                  r_cnt   <= '0;
               end
            end
            RUN: begin
               r_a     <= {1'b0, r_a[WIDTH-1:1]};
               r_b     <= {1'b0, r_b[WIDTH-1:1]};
               r_res   <= {w_s, r_res[WIDTH-1:1]};
               r_carry <= w_c_next;
               r_cnt   <= r_cnt + 1'b1;
               // Last bit goes straight into sum alongside the final carry
               if (w_last) begin
                  r_sum <= {w_c_next, w_s, r_res[WIDTH-1:1]};
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy = (r_state == RUN);
   assign done = (r_state == DONE);
   assign sum  = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
//==============================================================================
// Module      : tb_serial_adder
// Description : Scoreboard-based self-checking bench for serial_adder.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_serial_adder;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W:0]   sum;

   logic [W:0]   exp_q[$];
   int           n_cmp;
   int           n_err;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy cyc %0d: got %b want 0", i, busy); end
         n_cmp++;
         if (done !== 1'b0) begin n_err++; $display("FAIL reset_done cyc %0d: got %b want 0", i, done); end
         n_cmp++;
         if (sum !== 9'h000) begin n_err++; $display("FAIL reset_sum cyc %0d: got %h want 000", i, sum); end
      end
      rst = 1'b0;
   endtask

   task automatic test_basic;
      int          n_busy;
      int          n_done;
      int          first_done;
      logic [W:0]  exp;
      logic        held;
      n_busy = 0; n_done = 0; first_done = -1; held = 1'b1;
      @(negedge clk);
      a = 8'h03; b = 8'h05; start = 1'b1;
      exp_q.push_back(9'h008);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 14; i++) begin
         if (busy === 1'b1) begin
            n_busy++;
            if (sum !== 9'h000) held = 1'b0;
         end
         if (done === 1'b1) begin
            n_done++;
            if (first_done < 0) first_done = i;
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL basic_sum: done with empty scoreboard, got %h", sum); end
            else begin
               exp = exp_q.pop_front();
               if (sum !== exp) begin n_err++; $display("FAIL basic_sum: got %h want %h", sum, exp); end
            end
         end
         @(negedge clk);
      end
      n_cmp++;
      if (n_busy != 8) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 8", n_busy); end
      n_cmp++;
      if (n_done != 1) begin n_err++; $display("FAIL basic_done_count: got %0d want 1", n_done); end
      n_cmp++;
      if (first_done != 8) begin n_err++; $display("FAIL basic_done_latency: got %0d want 8", first_done); end
      n_cmp++;
      if (held !== 1'b1) begin n_err++; $display("FAIL basic_sum_hold: sum changed during RUN, got %b want 1", held); end
   endtask

   task automatic test_ops(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb);
      logic [W:0] exp;
      bit         seen;
      seen = 1'b0;
      @(negedge clk);
      a = xa; b = xb; start = 1'b1;
      exp_q.push_back({1'b0, xa} + {1'b0, xb});
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (done === 1'b1) begin
            seen = 1'b1;
            n_cmp++;
            exp = exp_q.pop_front();
            if (sum !== exp) begin n_err++; $display("FAIL %s: %h+%h got %h want %h", name, xa, xb, sum, exp); end
         end
         @(negedge clk);
      end
      if (!seen) begin
         n_cmp++; n_err++;
         $display("FAIL %s_timeout: got no done want done", name);
         void'(exp_q.pop_front());
      end
   endtask

   task automatic test_carry;
      test_ops("carry_ff_01", 8'hFF, 8'h01);
      test_ops("carry_ff_ff", 8'hFF, 8'hFF);
      test_ops("zero_zero",   8'h00, 8'h00);
   endtask

   task automatic test_back_to_back;
      int         n_done;
      int         last_done;
      logic [W:0] exp;
      n_done = 0; last_done = -1;
      @(negedge clk);
      a = 8'h10; b = 8'h20; start = 1'b1;
      for (int k = 0; k < 3; k++) exp_q.push_back(9'h030);
      @(negedge clk);
      for (int i = 0; i < 30; i++) begin
         if (i == 29) start = 1'b0;
         if (done === 1'b1) begin
            n_done++;
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_sum: extra done, got %h", sum); end
            else begin
               exp = exp_q.pop_front();
               if (sum !== exp) begin n_err++; $display("FAIL b2b_sum: got %h want %h", sum, exp); end
            end
            if (last_done >= 0) begin
               n_cmp++;
               if (i - last_done != 10) begin n_err++; $display("FAIL b2b_period: got %0d want 10", i - last_done); end
            end
            last_done = i;
         end
         @(negedge clk);
      end
      n_cmp++;
      if (n_done != 3) begin n_err++; $display("FAIL b2b_done_count: got %0d want 3", n_done); end
      while (exp_q.size() > 0) void'(exp_q.pop_front());
   endtask

   task automatic test_operand_change;
      int         n_done;
      logic [W:0] exp;
      n_done = 0;
      @(negedge clk);
      a = 8'h01; b = 8'h01; start = 1'b1;
      exp_q.push_back(9'h002);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i == 3) begin a = 8'hAA; start = 1'b1; end
         if (i == 4) start = 1'b0;
         if (done === 1'b1) begin
            n_done++;
            n_cmp++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL opchg_sum: extra done, got %h", sum); end
            else begin
               exp = exp_q.pop_front();
               if (sum !== exp) begin n_err++; $display("FAIL opchg_sum: got %h want %h", sum, exp); end
            end
         end
         @(negedge clk);
      end
      n_cmp++;
      if (n_done != 1) begin n_err++; $display("FAIL opchg_done_count: got %0d want 1", n_done); end
   endtask

   task automatic test_reset_abort;
      int n_done;
      n_done = 0;
      @(negedge clk);
      a = 8'h7F; b = 8'h01; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
      n_cmp++;
      if (sum !== 9'h000) begin n_err++; $display("FAIL abort_sum: got %h want 000", sum); end
      for (int i = 0; i < 12; i++) begin
         if (done === 1'b1) n_done++;
         @(negedge clk);
      end
      n_cmp++;
      if (n_done != 0) begin n_err++; $display("FAIL abort_done_count: got %0d want 0", n_done); end
      n_cmp++;
      if (sum !== 9'h000) begin n_err++; $display("FAIL abort_sum_after: got %h want 000", sum); end
   endtask

   task automatic test_random;
      for (int k = 0; k < 6; k++) begin
         test_ops("random", W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_basic();
      test_carry();
      test_back_to_back();
      test_operand_change();
      test_reset_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
